// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multicycle control unit for the 16-bit datapath. A Moore state register
// sequences each instruction through fetch / decode / execute / memory /
// writeback. It stalls in FETCH, MEM_RD and MEM_WR until MEM_READY is high.
// ALUSRCB and PCSRC drive the S inputs of the downstream mux4b4 instances.
//
// Optional feature (compile-time macro MC_CONTROL_ILLEGAL_TRAP_EN):
//   When the macro is defined, an illegal opcode in DECODE enters TRAP for one
//   cycle. TRAP loads the PC from the trap vector and pulses FAULT.
//   When the macro is undefined, an illegal opcode is a NOP (DECODE -> FETCH)
//   and FAULT is tied to 0.
//
// Parameters:
//   OPW          opcode width (IR[15:12])
//   TRAP_VEC_SEL PCSRC code that selects the trap vector (feature build only)
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   OPCODE       in   instruction opcode, valid from DECODE onward
//   ZERO         in   ALU zero flag (the datapath does the PCWRITECOND AND)
//   MEM_READY    in   memory has completed the current access this cycle
//   ALUSRCA      out  0=PC, 1=reg A
//   ALUSRCB      out  00=reg B, 01=const 1, 10=sign-ext imm, 11=zero
//   ALUOP        out  00=add, 01=sub, 10=use funct
//   PCSRC        out  00=ALU result, 01=ALUOUT, 10=jump target, 11=trap vector
//   PCWRITE      out  unconditional PC load
//   PCWRITECOND  out  PC load qualified by ZERO
//   IORD         out  memory address: 0=PC, 1=ALUOUT
//   MEMREAD      out  memory read request
//   MEMWRITE     out  memory write request
//   IRWRITE      out  instruction register load
//   REGWRITE     out  register file write
//   REGDST       out  0=rt, 1=rd
//   MEMTOREG     out  0=ALUOUT, 1=MDR
//   HALTED       out  FSM parked in HALT
//   FAULT        out  illegal-opcode pulse (feature build only, else 0)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int          OPW          = 4,
    parameter logic [1:0]  TRAP_VEC_SEL = 2'b11
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [OPW-1:0] OPCODE,
    input  logic           ZERO,
    input  logic           MEM_READY,
    output logic           ALUSRCA,
    output logic [1:0]     ALUSRCB,
    output logic [1:0]     ALUOP,
    output logic [1:0]     PCSRC,
    output logic           PCWRITE,
    output logic           PCWRITECOND,
    output logic           IORD,
    output logic           MEMREAD,
    output logic           MEMWRITE,
    output logic           IRWRITE,
    output logic           REGWRITE,
    output logic           REGDST,
    output logic           MEMTOREG,
    output logic           HALTED,
    output logic           FAULT
);

    localparam logic [OPW-1:0] OP_R    = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_LW   = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_J    = OPW'(4'b0101);
    localparam logic [OPW-1:0] OP_HALT = OPW'(4'b1111);

    typedef enum logic [3:0] {
        RST_ST      = 4'd0,
        FETCH_ST    = 4'd1,
        DECODE_ST   = 4'd2,
        EXEC_R_ST   = 4'd3,
        WB_R_ST     = 4'd4,
        EXEC_I_ST   = 4'd5,
        WB_I_ST     = 4'd6,
        MEM_ADDR_ST = 4'd7,
        MEM_RD_ST   = 4'd8,
        MEM_WB_ST   = 4'd9,
        MEM_WR_ST   = 4'd10,
        BRANCH_ST   = 4'd11,
        JUMP_ST     = 4'd12,
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
        TRAP_ST     = 4'd14,
`endif
        HALT_ST     = 4'd13
    } state_t;

    state_t state_q;
    state_t state_d;

    // ZERO is consumed by the datapath, not by the sequencer. The trap
    // selector only matters when the trap feature is built in.
    logic unused_inputs;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    assign unused_inputs = ZERO;
`else
    assign unused_inputs = ZERO ^ (^TRAP_VEC_SEL);
`endif

    // NOTE: the state register uses non-blocking assignment so every flop
    // samples the pre-edge value of state_d; blocking here would create
    // order-dependent simulation that does not match the synthesized flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RST_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output and state_d gets a default before the case, so
        // no path through the case leaves a signal unassigned (no latches).
        state_d     = state_q;
        ALUSRCA     = 1'b0;
        ALUSRCB     = 2'b00;
        ALUOP       = 2'b00;
        PCSRC       = 2'b00;
        PCWRITE     = 1'b0;
        PCWRITECOND = 1'b0;
        IORD        = 1'b0;
        MEMREAD     = 1'b0;
        MEMWRITE    = 1'b0;
        IRWRITE     = 1'b0;
        REGWRITE    = 1'b0;
        REGDST      = 1'b0;
        MEMTOREG    = 1'b0;
        HALTED      = 1'b0;
        FAULT       = 1'b0;

        case (state_q)
            RST_ST: begin
                state_d = FETCH_ST;
            end

            FETCH_ST: begin
                // PC+1 is computed in the ALU. The PC and IR load only on
                // the cycle the instruction word actually arrives.
                MEMREAD = 1'b1;
                ALUSRCB = 2'b01;
                IRWRITE = MEM_READY;
                PCWRITE = MEM_READY;
                if (MEM_READY) begin
                    state_d = DECODE_ST;
                end
            end

            DECODE_ST: begin
                // Branch target (PC + imm) is precomputed into ALUOUT.
                ALUSRCB = 2'b10;
                unique case (OPCODE)
                    OP_R:         state_d = EXEC_R_ST;
                    OP_ADDI:      state_d = EXEC_I_ST;
                    OP_LW, OP_SW: state_d = MEM_ADDR_ST;
                    OP_BEQ:       state_d = BRANCH_ST;
                    OP_J:         state_d = JUMP_ST;
                    OP_HALT:      state_d = HALT_ST;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP_ST;
`else
                    default:      state_d = FETCH_ST;
`endif
                endcase
            end

            EXEC_R_ST: begin
                ALUSRCA = 1'b1;
                ALUOP   = 2'b10;
                state_d = WB_R_ST;
            end

            WB_R_ST: begin
                REGWRITE = 1'b1;
                REGDST   = 1'b1;
                state_d  = FETCH_ST;
            end

            EXEC_I_ST: begin
                ALUSRCA = 1'b1;
                ALUSRCB = 2'b10;
                state_d = WB_I_ST;
            end

            WB_I_ST: begin
                REGWRITE = 1'b1;
                state_d  = FETCH_ST;
            end

            MEM_ADDR_ST: begin
                ALUSRCA = 1'b1;
                ALUSRCB = 2'b10;
                // The opcode is sampled again here. If it is no longer a
                // load or store, the instruction is dropped instead of
                // issuing a stray memory access.
                if (OPCODE == OP_LW) begin
                    state_d = MEM_RD_ST;
                end else if (OPCODE == OP_SW) begin
                    state_d = MEM_WR_ST;
                end else begin
                    state_d = FETCH_ST;
                end
            end

            MEM_RD_ST: begin
                MEMREAD = 1'b1;
                IORD    = 1'b1;
                if (MEM_READY) begin
                    state_d = MEM_WB_ST;
                end
            end

            MEM_WB_ST: begin
                REGWRITE = 1'b1;
                MEMTOREG = 1'b1;
                state_d  = FETCH_ST;
            end

            MEM_WR_ST: begin
                MEMWRITE = 1'b1;
                IORD     = 1'b1;
                if (MEM_READY) begin
                    state_d = FETCH_ST;
                end
            end

            BRANCH_ST: begin
                ALUSRCA     = 1'b1;
                ALUOP       = 2'b01;
                PCWRITECOND = 1'b1;
                PCSRC       = 2'b01;
                state_d     = FETCH_ST;
            end

            JUMP_ST: begin
                PCWRITE = 1'b1;
                PCSRC   = 2'b10;
                state_d = FETCH_ST;
            end

            HALT_ST: begin
                HALTED  = 1'b1;
                state_d = HALT_ST;
            end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            TRAP_ST: begin
                PCWRITE = 1'b1;
                PCSRC   = TRAP_VEC_SEL;
                FAULT   = 1'b1;
                state_d = FETCH_ST;
            end
`endif

            default: begin
                // Unused encodings drive all outputs to 0 for one cycle and
                // then resume normal operation at FETCH.
                state_d = FETCH_ST;
            end
        endcase
    end

endmodule
